mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences a single-port unified instruction/data memory shared between the pipeline's fetch stage and its memory stage.
- Arbitrates between the two requesters and runs one memory transaction at a time through a request/grant plus read-response handshake.
- Returns the result to the winning requester and drives a pipeline-wide stall while any request is outstanding.
- Includes a response watchdog so a dead memory cannot hang the core.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
TIMEOUT_CYCLES, 64, maximum cycles spent in REQ+RESP before the transaction is aborted (>=2)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_ni  in  1  asynchronous active-low reset
if_req_i  in  1  fetch read request; level, held until if_ack_o
if_addr_i  in  ADDR_WIDTH  fetch address; stable while if_req_i
if_ack_o  out  1  one-cycle completion pulse to fetch
if_rdata_o  out  DATA_WIDTH  fetched word; valid with if_ack_o
d_req_i  in  1  data request; level, held until d_ack_o
d_we_i  in  1  1 = store, 0 = load
d_be_i  in  DATA_WIDTH/8  store byte enables
d_addr_i  in  ADDR_WIDTH  data address
d_wdata_i  in  DATA_WIDTH  store data
d_ack_o  out  1  one-cycle completion pulse to data port
d_rdata_o  out  DATA_WIDTH  load data; valid with d_ack_o
err_o  out  1  high with the ack of an aborted (timed-out) transaction
stall_o  out  1  pipeline stall
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write
mem_be_o  out  DATA_WIDTH/8  memory byte enables
mem_addr_o  out  ADDR_WIDTH  memory address
mem_wdata_o  out  DATA_WIDTH  memory write data
mem_gnt_i  in  1  memory accepts request (transfer = mem_req_o & mem_gnt_i)
mem_rvalid_i  in  1  read response valid, at least 1 cycle after the read grant
mem_rdata_i  in  DATA_WIDTH  read response data

Behaviour:
- Reset (async, rst_ni low):
  - state = IDLE, watchdog counter = 0, last_grant = FETCH.
  - All registered outputs are 0: acks, rdata, err_o, mem_* outputs.
  - A reset mid-transaction abandons it; no ack is issued.
- FSM states: IDLE, REQ, RESP, ACK.
- IDLE: sample the requests.
  - Only one request: it wins.
  - Both requests: data wins unless last_grant = DATA, in which case fetch wins (alternation prevents starvation).
  - On a winner: latch owner, we (fetch always read), be (fetch = all ones), addr, wdata into the mem_* registers; update last_grant; go to REQ.
- REQ: mem_req_o = 1 with the latched fields held constant.
  - Grant on a write: go to ACK.
  - Grant on a read: go to RESP.
  - No grant: stay in REQ.
- RESP: wait for mem_rvalid_i, then capture mem_rdata_i into the owner's rdata register and go to ACK.
  - mem_rvalid_i in the same cycle as the grant is not accepted; the response must come at least one cycle later.
  - mem_rvalid_i is ignored in every state other than RESP.
- ACK: exactly one cycle.
  - The owner's ack_o is high and its rdata_o is valid; writes return rdata = 0.
  - No arbitration occurs in ACK, so a requester can drop its request on the edge after seeing ack.
  - Next state is IDLE.
- Minimum latency, request sampled to ack:
  - Write: 2 cycles (IDLE→REQ→ACK, grant in the first REQ cycle).
  - Read: 3 cycles (IDLE→REQ→RESP→ACK, rvalid in the first RESP cycle).
- Watchdog:
  - Counter clears on entering REQ and increments each cycle in REQ or RESP.
  - When it reaches TIMEOUT_CYCLES-1 without completion, the next state is ACK with err_o = 1 and rdata = 0.
  - mem_req_o deasserts on leaving REQ.
- err_o: high only during ACK of an aborted transaction; otherwise 0.
- rdata_o: holds its last value outside ACK.
- stall_o (combinational) = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o). It is low in the ACK cycle if only the owner was requesting.
- Only one transaction is in flight at any time. mem_req_o is never high outside REQ.

Test Plan:
- Single fetch, addr 0x100, gnt immediate, rvalid 1 cycle later with 0xDEADBEEF -> if_ack_o pulses 3 cycles after sampling with if_rdata_o = 0xDEADBEEF, err_o = 0, stall_o high until the ack cycle.
- Data store addr 0x2000, be 4'b0011, wdata 0x1234, gnt delayed 3 cycles -> mem_req_o held for 4 cycles with constant fields, mem_we_o = 1; d_ack_o pulses the cycle after the grant; fetch is not acked.
- Simultaneous fetch and load held for 4 transactions after reset -> grant order data, fetch, data, fetch; each ack is a single-cycle pulse; no transaction is started during an ACK cycle.
- Load with mem_gnt_i never asserted, TIMEOUT_CYCLES = 8 -> d_ack_o and err_o pulse together, d_rdata_o = 0, mem_req_o low afterwards; next fetch completes normally with err_o = 0.
- Stray mem_rvalid_i pulse in IDLE, then a read whose real rvalid carries 0xA5A5A5A5 -> stray pulse ignored; requester receives 0xA5A5A5A5.
- rst_ni low while in RESP -> all outputs 0 immediately, state IDLE; no ack after release; a held request is re-arbitrated from scratch.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data ports,
// one transaction at a time, with a response watchdog.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_ack_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [DATA_WIDTH/8-1:0] d_be_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  output logic                    d_ack_o,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    err_o,
  output logic                    stall_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, REQ, RESP, ACK} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic last_data, owner_data, pick_data, done, timeout;
  logic [DATA_WIDTH-1:0] ack_data;
  always_comb begin
    pick_data = d_req_i & (~if_req_i | ~last_data);
    done      = (state == REQ & mem_gnt_i & mem_we_o) | (state == RESP & mem_rvalid_i);
    // a read granted in the last allowed cycle cannot finish in time and is aborted too
    timeout   = (state == REQ | state == RESP) & (cnt == CW'(TIMEOUT_CYCLES - 1)) & ~done;
    ack_data  = (state == RESP & mem_rvalid_i) ? mem_rdata_i : '0;
    state_n   = timeout        ? ACK :
                state == IDLE  ? ((if_req_i | d_req_i) ? REQ : IDLE) :
                state == REQ   ? (mem_gnt_i ? (mem_we_o ? ACK : RESP) : REQ) :
                state == RESP  ? (mem_rvalid_i ? ACK : RESP) : IDLE;
    stall_o   = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o);
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      last_data   <= 1'b0;
      owner_data  <= 1'b0;
      if_ack_o    <= 1'b0;
      d_ack_o     <= 1'b0;
      err_o       <= 1'b0;
      if_rdata_o  <= '0;
      d_rdata_o   <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      state     <= state_n;
      cnt       <= (state == IDLE) ? '0 : cnt + 1'b1;
      mem_req_o <= state_n == REQ;
      if_ack_o  <= state_n == ACK & ~owner_data;
      d_ack_o   <= state_n == ACK & owner_data;
      err_o     <= timeout;
      if (state == IDLE & state_n == REQ) begin
        owner_data  <= pick_data;
        last_data   <= pick_data;
        mem_we_o    <= pick_data & d_we_i;
        mem_be_o    <= pick_data ? d_be_i : '1;
        mem_addr_o  <= pick_data ? d_addr_i : if_addr_i;
        mem_wdata_o <= pick_data ? d_wdata_i : '0;
      end
      if (state_n == ACK & ~owner_data) if_rdata_o <= ack_data;
      if (state_n == ACK & owner_data) d_rdata_o <= ack_data;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table, hand sequences for arbitration/reset,
// and a randomized run against a transaction-level timing model.
module tb_mem_port_arbiter;
  localparam int T = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic if_req = 0, d_req = 0, d_we = 0, gnt = 0, rvalid = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mrdata = 0;
  logic [3:0] d_be = 0;
  logic if_ack_o, d_ack_o, err_o, stall_o, mem_req_o, mem_we_o;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
  logic [3:0] mem_be_o;
  int n_vec = 0, n_bad = 0;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o), .err_o(err_o), .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(mrdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fetch;
    int          g;
    int          r;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rd;
    int          lat;
    logic        err;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {27'd0, if_ack_o, d_ack_o, err_o, mem_req_o, mem_we_o}, 0);
    chk({tag, "_be"}, {28'd0, mem_be_o}, 0);
    chk({tag, "_addr"}, mem_addr_o, 0);
    chk({tag, "_wdata"}, mem_wdata_o, 0);
    chk({tag, "_if_rdata"}, if_rdata_o, 0);
    chk({tag, "_d_rdata"}, d_rdata_o, 0);
  endtask

  // g = REQ cycles before grant, r = cycles from grant to rvalid
  task automatic run_vec(input vec_t v, input bit held);
    bit got = 0;
    int req_end = (v.g < T) ? 1 + v.g : T;
    if (!held) @(negedge clk);
    if_req = v.fetch; if_addr = v.addr;
    d_req = !v.fetch; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
    gnt = 0; rvalid = 0;
    for (int k = 1; k <= 30 && !got; k++) begin
      @(negedge clk);
      chk("mem_req", {31'd0, mem_req_o}, {31'd0, k <= req_end});
      if (mem_req_o) begin
        chk("mem_addr", mem_addr_o, v.addr);
        chk("mem_we", {31'd0, mem_we_o}, {31'd0, !v.fetch && v.we});
        chk("mem_be", {28'd0, mem_be_o}, {28'd0, v.fetch ? 4'hF : v.be});
        if (!v.fetch && v.we) chk("mem_wdata", mem_wdata_o, v.wdata);
      end
      if (if_ack_o | d_ack_o) begin
        got = 1;
        chk("latency", k, v.lat);
        chk("owner", {30'd0, if_ack_o, d_ack_o}, v.fetch ? 2 : 1);
        chk("err", {31'd0, err_o}, {31'd0, v.err});
        chk("rdata", v.fetch ? if_rdata_o : d_rdata_o, v.exp_rd);
        chk("stall_ack", {31'd0, stall_o}, 0);
        if_req = 0; d_req = 0;
      end else chk("stall_wait", {31'd0, stall_o}, 1);
      gnt = (k == 1 + v.g);
      rvalid = (k == 1 + v.g + v.r);
      mrdata = rvalid ? v.rd : $urandom;
    end
    if (!got) begin
      chk("ack_seen", 0, 1);
      if_req = 0; d_req = 0;
    end
    gnt = 0; rvalid = 0;
    @(negedge clk);
    chk("ack_pulse", {28'd0, if_ack_o, d_ack_o, err_o, mem_req_o}, 0);
  endtask

  // random-phase model state
  int cyc, s, g, r, ack_c, req_end, n;
  logic busy, w_d, t_we, t_err, last_d, ea, eif, ed, ereq, pend, prev_ack;
  logic [31:0] t_addr, t_wd, t_rd, e_if_rd, e_d_rd;
  logic [3:0] t_be;
  vec_t v;

  initial begin
    tbl[0]  = '{1'b1, 0,  1, 32'h100,  4'hF, 32'h0,        1'b0, 32'hDEADBEEF, 3, 1'b0, 32'hDEADBEEF};
    tbl[1]  = '{1'b0, 3,  1, 32'h2000, 4'h3, 32'h1234,     1'b1, 32'h0,        5, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 0,  1, 32'h40,   4'hF, 32'h0,        1'b0, 32'h11112222, 3, 1'b0, 32'h11112222};
    tbl[3]  = '{1'b0, 2,  3, 32'h44,   4'hF, 32'h0,        1'b0, 32'h33334444, 7, 1'b0, 32'h33334444};
    tbl[4]  = '{1'b0, 99, 1, 32'h48,   4'hF, 32'h0,        1'b0, 32'hBBBBBBBB, 9, 1'b1, 32'h0};
    tbl[5]  = '{1'b1, 4,  3, 32'h104,  4'hF, 32'h0,        1'b0, 32'h55556666, 9, 1'b0, 32'h55556666};
    tbl[6]  = '{1'b1, 4,  4, 32'h108,  4'hF, 32'h0,        1'b0, 32'h77778888, 9, 1'b1, 32'h0};
    tbl[7]  = '{1'b0, 7,  1, 32'h3000, 4'hC, 32'hCAFE0000, 1'b1, 32'h0,        9, 1'b0, 32'h0};
    tbl[8]  = '{1'b0, 8,  1, 32'h3004, 4'h1, 32'h11,       1'b1, 32'h0,        9, 1'b1, 32'h0};
    tbl[9]  = '{1'b0, 7,  1, 32'h4C,   4'hF, 32'h0,        1'b0, 32'hCCCCCCCC, 9, 1'b1, 32'h0};
    tbl[10] = '{1'b1, 1,  2, 32'h10C,  4'hF, 32'h0,        1'b0, 32'h99990000, 5, 1'b0, 32'h99990000};

    repeat (2) @(negedge clk);
    chk_zero("reset");
    chk("reset_stall", {31'd0, stall_o}, 0);
    rst_n = 1;

    // both ports held: data, fetch, data, fetch
    @(negedge clk);
    if_req = 1; if_addr = 32'h300; d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h400; d_wdata = 0;
    n = 0; prev_ack = 0; pend = 0;
    for (int k = 0; k < 60 && n < 4; k++) begin
      @(negedge clk);
      chk("stall_both", {31'd0, stall_o}, 1);
      if (prev_ack) chk("idle_after_ack", {29'd0, if_ack_o, d_ack_o, mem_req_o}, 0);
      if (if_ack_o | d_ack_o) begin
        chk("grant_order", {30'd0, if_ack_o, d_ack_o}, (n % 2 == 0) ? 1 : 2);
        n++;
      end
      prev_ack = if_ack_o | d_ack_o;
      rvalid = pend; pend = mem_req_o; gnt = mem_req_o; mrdata = $urandom;
    end
    chk("both_done", n, 4);
    if_req = 0; d_req = 0; gnt = 0; rvalid = 0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(tbl[i], 0);

    // stray rvalid while idle must be ignored
    @(negedge clk);
    rvalid = 1; mrdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("stray_noack", {30'd0, if_ack_o, d_ack_o}, 0);
    rvalid = 0;
    v = '{1'b1, 0, 1, 32'h200, 4'hF, 32'h0, 1'b0, 32'hA5A5A5A5, 3, 1'b0, 32'hA5A5A5A5};
    run_vec(v, 0);

    // reset while waiting in RESP, request kept high
    @(negedge clk);
    d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'h80; if_req = 0;
    @(negedge clk); gnt = 1;
    @(negedge clk); gnt = 0;
    rst_n = 0;
    #1 chk_zero("rst_resp");
    @(negedge clk);
    chk_zero("rst_hold");
    rst_n = 1;
    v = '{1'b0, 0, 1, 32'h80, 4'hF, 32'h0, 1'b0, 32'h5555AAAA, 3, 1'b0, 32'h5555AAAA};
    run_vec(v, 1);

    // randomized traffic against a transaction-level timing model
    @(negedge clk);
    rst_n = 0; if_req = 0; d_req = 0; gnt = 0; rvalid = 0;
    @(negedge clk);
    rst_n = 1;
    cyc = 0; busy = 0; last_d = 0; e_if_rd = 0; e_d_rd = 0; w_d = 0; t_we = 0; t_err = 0;
    s = 0; g = 0; r = 0; ack_c = 0; req_end = 0; t_rd = 0; t_addr = 0; t_wd = 0; t_be = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cyc++;
      ea = busy && cyc == ack_c;
      eif = ea && !w_d;
      ed = ea && w_d;
      if (ed) e_d_rd = (t_we || t_err) ? 32'h0 : t_rd;
      if (eif) e_if_rd = t_err ? 32'h0 : t_rd;
      chk("r_if_ack", {31'd0, if_ack_o}, {31'd0, eif});
      chk("r_d_ack", {31'd0, d_ack_o}, {31'd0, ed});
      chk("r_err", {31'd0, err_o}, {31'd0, ea && t_err});
      chk("r_if_rdata", if_rdata_o, e_if_rd);
      chk("r_d_rdata", d_rdata_o, e_d_rd);
      ereq = busy && cyc > s && cyc <= req_end;
      chk("r_mem_req", {31'd0, mem_req_o}, {31'd0, ereq});
      if (ereq) begin
        chk("r_addr", mem_addr_o, t_addr);
        chk("r_we", {31'd0, mem_we_o}, {31'd0, t_we});
        chk("r_be", {28'd0, mem_be_o}, {28'd0, t_be});
        if (t_we) chk("r_wdata", mem_wdata_o, t_wd);
      end
      chk("r_stall", {31'd0, stall_o}, {31'd0, (if_req && !eif) || (d_req && !ed)});
      if (ea) busy = 0;
      if (eif || !if_req) begin
        if_req = ($urandom % 3) == 0; if_addr = $urandom;
      end
      if (ed || !d_req) begin
        d_req = ($urandom % 3) == 0; d_we = 1'($urandom); d_be = 4'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end
      if (!busy && !ea && (if_req || d_req)) begin
        s = cyc;
        w_d = d_req && (!if_req || !last_d);
        last_d = w_d;
        t_we = w_d && d_we;
        t_be = w_d ? d_be : 4'hF;
        t_addr = w_d ? d_addr : if_addr;
        t_wd = d_wdata;
        g = $urandom % 10;
        r = 1 + $urandom % 4;
        t_rd = $urandom;
        t_err = t_we ? (g + 1 > T) : (g + 1 + r > T);
        ack_c = t_err ? s + 1 + T : t_we ? s + 2 + g : s + 2 + g + r;
        req_end = (g < T) ? s + 1 + g : s + T;
        busy = 1;
      end
      gnt = busy && g < T && cyc == s + 1 + g;
      rvalid = busy ? (!t_we && !t_err && cyc == s + 1 + g + r) : (($urandom % 8) == 0);
      mrdata = (busy && rvalid) ? t_rd : $urandom;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
